// File: rtl/tx_gbox_pkg.sv
// Shared constants and block type for the 64b/66b TX gearbox.
//   BLK_W / WORD_W / BUF_W : block, line word and bit-buffer widths
//   HDR_DATA / HDR_CTRL    : 64b/66b sync header values
//   IDLE_PAYLOAD_DEFAULT   : payload of an inserted idle control block
//   SCR_SEED_DEFAULT       : scrambler reset state
//   blk_t                  : {hdr, payload}, hdr occupies bits [65:64]
package tx_gbox_pkg;
  localparam int BLK_W  = 66;
  localparam int WORD_W = 32;
  localparam int BUF_W  = 98;

  localparam logic [1:0]  HDR_DATA = 2'b01;
  localparam logic [1:0]  HDR_CTRL = 2'b10;

  localparam logic [63:0] IDLE_PAYLOAD_DEFAULT = 64'h7800_0000_0000_0000;
  localparam logic [57:0] SCR_SEED_DEFAULT     = 58'h3FF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] payload;
  } blk_t;
endpackage

// File: rtl/tx_scrambler64.sv
// Self-synchronous scrambler, polynomial 1 + x^39 + x^58, 64 bits per call.
//   clk_i, rst_i : clock, async active-low reset (state -> SEED)
//   adv_i        : commit the post-scramble state (one block appended)
//   data_i       : plaintext payload, bit 63 processed first
//   data_o       : scrambled payload (combinational from data_i and state)
module tx_scrambler64
  import tx_gbox_pkg::*;
#(
  parameter logic [57:0] SEED = SCR_SEED_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);
  logic [57:0] st_q, st_d;
  logic        s;

  // Unrolled serial recurrence: each scrambled bit feeds back into the state.
  always_comb begin
    st_d   = st_q;
    data_o = '0;
    s      = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      s         = data_i[i] ^ st_d[38] ^ st_d[57];
      data_o[i] = s;
      st_d      = {st_d[56:0], s};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     st_q <= SEED;
    else if (adv_i) st_q <= st_d;
  end
endmodule

// File: rtl/tx_gearbox_66to32.sv
// TX gearbox: 66-bit blocks in, one continuous 32-bit line word per clock out.
// Inserts idle control blocks when the source is dry (IDLE_INSERT = 1).
// Optional payload scrambling is built when TX_GBOX_SCRAMBLER_EN is defined.
//   clk_i, rst_i  : clock, async active-low reset
//   blk_i         : [65:64] sync header, [63:0] payload
//   blk_valid_i   : blk_i valid; taken on an edge where blk_ready_o is high
//   blk_ready_o   : decoded from registered fill, independent of blk_valid_i
//   word_o        : line word, bit 31 transmitted first
//   word_valid_o  : word_o carries line data
//   fill_o        : bits held in the buffer (debug)
//   idle_cnt_o    : inserted idle blocks, saturating
module tx_gearbox_66to32
  import tx_gbox_pkg::*;
#(
  parameter bit          IDLE_INSERT  = 1'b1,
  parameter logic [63:0] IDLE_PAYLOAD = IDLE_PAYLOAD_DEFAULT,
  parameter logic [57:0] SCR_SEED     = SCR_SEED_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BLK_W-1:0]  blk_i,
  input  logic              blk_valid_i,
  output logic              blk_ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  output logic [6:0]        fill_o,
  output logic [15:0]       idle_cnt_o
);
  logic [BUF_W-1:0]  buf_q, buf_d, buf_rem;
  logic [6:0]        fill_q, fill_d, rem;
  logic [WORD_W-1:0] word_q;
  logic              wvld_q;
  logic [15:0]       idle_q;
  logic              ready, emit, append, take_idle;
  logic [63:0]       pay_raw, pay_app;
  blk_t              blk_in, blk_app;

  // fill < 64 at this edge is the same as "rem after the previous edge < 32";
  // gating with rst_i lets the first edge after release already accept.
  assign ready       = (fill_q < 7'd64);
  assign blk_ready_o = rst_i & ready;
  assign blk_in      = blk_i;

  assign pay_raw = blk_valid_i ? blk_in.payload : IDLE_PAYLOAD;

`ifdef TX_GBOX_SCRAMBLER_EN
  tx_scrambler64 #(.SEED(SCR_SEED)) u_scr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .adv_i  (append),
    .data_i (pay_raw),
    .data_o (pay_app)
  );
`else
  logic [57:0] unused_seed;
  assign unused_seed = SCR_SEED;
  assign pay_app     = pay_raw;
`endif

  always_comb begin
    emit      = (fill_q >= 7'd32);
    rem       = emit ? (fill_q - 7'd32) : fill_q;
    buf_rem   = emit ? {buf_q[BUF_W-WORD_W-1:0], {WORD_W{1'b0}}} : buf_q;
    take_idle = ready && !blk_valid_i && IDLE_INSERT;
    append    = ready && (blk_valid_i || IDLE_INSERT);
    blk_app.hdr     = blk_valid_i ? blk_in.hdr : HDR_CTRL;
    blk_app.payload = pay_app;
    buf_d  = buf_rem;
    fill_d = rem;
    // rem < 32 whenever ready, so the block lands fully inside the buffer and
    // every bit below the fill level stays zero for the OR-append.
    if (append) begin
      buf_d  = buf_rem | ({blk_app, {WORD_W{1'b0}}} >> rem);
      fill_d = rem + 7'd66;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_q  <= '0;
      fill_q <= '0;
      word_q <= '0;
      wvld_q <= 1'b0;
      idle_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      wvld_q <= emit;
      if (emit) word_q <= buf_q[BUF_W-1 -: WORD_W];
      if (take_idle && idle_q != 16'hFFFF) idle_q <= idle_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) assert (fill_d <= 7'd97);
  end

  assign word_o       = word_q;
  assign word_valid_o = wvld_q;
  assign fill_o       = fill_q;
  assign idle_cnt_o   = idle_q;
endmodule

// File: tb/tb_tx_gearbox_66to32.sv
// Directed bench for tx_gearbox_66to32. Instance 0 inserts idles, instance 1
// holds off instead. A bit-queue scoreboard holds the expected line stream.
module tb_tx_gearbox_66to32;
  localparam logic [63:0] IDLE_P = 64'h7800_0000_0000_0000;

  logic        clk, rst_n;
  logic [65:0] bi  [2];
  logic        bv  [2];
  logic        rdy [2];
  logic [31:0] wo  [2];
  logic        wv  [2];
  logic [6:0]  fl  [2];
  logic [15:0] ic  [2];

  int tests, fails;
  bit exp_q[$];
  bit rhist[$];
  int se, nlow, hold_err, nwords, nb, tcnt;
  bit started, smp_v, last_rdy, acc;
  logic [31:0] last_w, f_act, f_exp;
`ifdef TX_GBOX_SCRAMBLER_EN
  logic [57:0] sc_st;
`endif

  tx_gearbox_66to32 #(.IDLE_INSERT(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_n), .blk_i(bi[0]), .blk_valid_i(bv[0]),
    .blk_ready_o(rdy[0]), .word_o(wo[0]), .word_valid_o(wv[0]),
    .fill_o(fl[0]), .idle_cnt_o(ic[0]));

  tx_gearbox_66to32 #(.IDLE_INSERT(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .blk_i(bi[1]), .blk_valid_i(bv[1]),
    .blk_ready_o(rdy[1]), .word_o(wo[1]), .word_valid_o(wv[1]),
    .fill_o(fl[1]), .idle_cnt_o(ic[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, need done");
    $fatal(1);
  end

  function automatic logic [65:0] mk(input int k);
    return {2'b01, 64'h0123_4567_89AB_CDEF + 64'(k)};
  endfunction

  task automatic push_blk(input logic [65:0] b);
    logic [65:0] x;
    x = b;
`ifdef TX_GBOX_SCRAMBLER_EN
    for (int i = 63; i >= 0; i--) begin
      logic s;
      s = x[i] ^ sc_st[38] ^ sc_st[57];
      x[i] = s;
      sc_st = {sc_st[56:0], s};
    end
`endif
    for (int i = 65; i >= 0; i--) exp_q.push_back(x[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bv[0] = 1'b0; bv[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.delete(); rhist.delete();
    started = 0; se = 0; nlow = 0; hold_err = 0; nwords = 0; nb = 0;
`ifdef TX_GBOX_SCRAMBLER_EN
    sc_st = 58'h3FF_FFFF_FFFF_FFFF;
`endif
  endtask

  // Drive one cycle on instance d, let the edge pass, score the result.
  task automatic tick(input int d, input logic v, input logic [65:0] b);
    logic [31:0] e;
    last_rdy = rdy[d];
    bv[d] = v; bi[d] = b; acc = 0;
    rhist.push_back(rdy[d]);
    if (rdy[d]) begin
      if (v) begin push_blk(b); acc = 1; nb++; end
      else if (d == 0) push_blk({2'b10, IDLE_P});
    end
    @(negedge clk); #1;
    tcnt++;
    smp_v = wv[d];
    if (wv[d]) begin
      started = 1; nwords++;
      if (exp_q.size() < 32) se++;
      else begin
        e = '0;
        for (int i = 31; i >= 0; i--) e[i] = exp_q.pop_front();
        if (wo[d] !== e) begin
          if (se == 0) begin f_act = wo[d]; f_exp = e; end
          se++;
        end
      end
      last_w = wo[d];
    end else if (started) begin
      nlow++;
      if (wo[d] !== last_w) hold_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bv[0] = 0; bv[1] = 0; bi[0] = '0; bi[1] = '0;
    #1;
    tests++; if (wo[0] !== 32'h0) begin fails++; $display("FAIL rst_word got %h need 0", wo[0]); end
    tests++; if (wv[0] !== 1'b0) begin fails++; $display("FAIL rst_wvalid got %b need 0", wv[0]); end
    tests++; if (rdy[0] !== 1'b0) begin fails++; $display("FAIL rst_ready got %b need 0", rdy[0]); end
    tests++; if (fl[0] !== 7'd0) begin fails++; $display("FAIL rst_fill got %0d need 0", fl[0]); end
    tests++; if (ic[0] !== 16'd0) begin fails++; $display("FAIL rst_idle got %0d need 0", ic[0]); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    tests++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL first_ready got %b need 1", rdy[0]); end
    bv[0] = 1'b1; bi[0] = {2'b01, 64'h0123_4567_89AB_CDEF};
    @(negedge clk); #1;
    tests++; if (fl[0] !== 7'd66) begin fails++; $display("FAIL fill_after_1 got %0d need 66", fl[0]); end
    tests++; if (wv[0] !== 1'b0) begin fails++; $display("FAIL wvalid_edge1 got %b need 0", wv[0]); end
    bi[0] = {2'b01, 64'hFEDC_BA98_7654_3210};
    @(negedge clk); #1;
    tests++; if (wv[0] !== 1'b1) begin fails++; $display("FAIL wvalid_edge2 got %b need 1", wv[0]); end
    tests++; if (wo[0] !== 32'h4048_D159) begin fails++; $display("FAIL first_word got %h need 4048d159", wo[0]); end
    tests++; if (fl[0] !== 7'd34) begin fails++; $display("FAIL fill_after_2 got %0d need 34", fl[0]); end
    rst_n = 1'b0; #1;
    tests++; if (wv[0] !== 1'b0) begin fails++; $display("FAIL async_wvalid got %b need 0", wv[0]); end
    tests++; if (rdy[0] !== 1'b0) begin fails++; $display("FAIL async_ready got %b need 0", rdy[0]); end
    tests++; if (fl[0] !== 7'd0) begin fails++; $display("FAIL async_fill got %0d need 0", fl[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    tests++; if (wv[0] !== 1'b1) begin fails++; $display("FAIL restart_wvalid got %b need 1", wv[0]); end
    tests++; if (wo[0] !== 32'h7FB7_2EA6) begin fails++; $display("FAIL restart_word got %h need 7fb72ea6", wo[0]); end
    bv[0] = 1'b0;
  endtask

  task automatic test_stream();
    int cyc, werr, c;
    do_reset();
    cyc = 0;
    while (nb < 1000 && cyc < 3000) begin tick(0, 1'b1, mk(nb)); cyc++; end
    werr = 0;
    for (int s = 33; s + 33 <= rhist.size(); s++) begin
      c = 0;
      for (int j = 0; j < 33; j++) c += int'(rhist[s+j]);
      if (c != 16) werr++;
    end
    tests++; if (nb !== 1000) begin fails++; $display("FAIL stream_blocks got %0d need 1000", nb); end
    tests++; if (se !== 0) begin fails++; $display("FAIL stream_bits errors %0d first got %h need %h", se, f_act, f_exp); end
    tests++; if (nlow !== 0) begin fails++; $display("FAIL stream_gaps got %0d need 0", nlow); end
    tests++; if (werr !== 0) begin fails++; $display("FAIL ready_windows bad %0d need 0", werr); end
    tests++; if (int'(fl[0]) !== exp_q.size()) begin fails++; $display("FAIL stream_fill got %0d need %0d", fl[0], exp_q.size()); end
  endtask

  task automatic test_idle_insert();
    int n, g;
    do_reset();
    for (int i = 0; i < 6; i++) tick(0, 1'b1, mk(nb));
    n = 0; g = 0;
    while (n < 3 && g < 20) begin tick(0, 1'b0, '0); if (last_rdy) n++; g++; end
    for (int i = 0; i < 10; i++) tick(0, 1'b1, mk(nb));
    tests++; if (n !== 3) begin fails++; $display("FAIL idle_stall_cycles got %0d need 3", n); end
    tests++; if (ic[0] !== 16'd3) begin fails++; $display("FAIL idle_cnt got %0d need 3", ic[0]); end
    tests++; if (se !== 0) begin fails++; $display("FAIL idle_bits errors %0d first got %h need %h", se, f_act, f_exp); end
    tests++; if (nlow !== 0) begin fails++; $display("FAIL idle_gaps got %0d need 0", nlow); end
    tests++; if (int'(fl[0]) !== exp_q.size()) begin fails++; $display("FAIL idle_fill got %0d need %0d", fl[0], exp_q.size()); end
  endtask

  task automatic test_hold_no_idle();
    int k;
    do_reset();
    for (int i = 0; i < 6; i++) tick(1, 1'b1, mk(nb));
    for (int i = 0; i < 6; i++) tick(1, 1'b0, '0);
    tests++; if (nlow == 0) begin fails++; $display("FAIL hold_drop got %0d low cycles need >0", nlow); end
    tick(1, 1'b1, mk(nb));
    k = 1;
    while (!smp_v && k < 6) begin tick(1, 1'b1, mk(nb)); k++; end
    tests++; if (k !== 2) begin fails++; $display("FAIL hold_resume got %0d cycles need 2", k); end
    for (int i = 0; i < 10; i++) tick(1, 1'b1, mk(nb));
    tests++; if (se !== 0) begin fails++; $display("FAIL hold_bits errors %0d first got %h need %h", se, f_act, f_exp); end
    tests++; if (hold_err !== 0) begin fails++; $display("FAIL hold_word_kept got %0d changes need 0", hold_err); end
    tests++; if (ic[1] !== 16'd0) begin fails++; $display("FAIL hold_idle_cnt got %0d need 0", ic[1]); end
    tests++; if (int'(fl[1]) !== exp_q.size()) begin fails++; $display("FAIL hold_fill got %0d need %0d", fl[1], exp_q.size()); end
  endtask

`ifdef TX_GBOX_SCRAMBLER_EN
  task automatic test_scrambler();
    int cyc;
    do_reset();
    cyc = 0;
    while (nb < 200 && cyc < 600) begin tick(0, 1'b1, {2'b01, 64'h0}); cyc++; end
    tests++; if (se !== 0) begin fails++; $display("FAIL scr_bits errors %0d first got %h need %h", se, f_act, f_exp); end
    tests++; if (nb !== 200) begin fails++; $display("FAIL scr_blocks got %0d need 200", nb); end
  endtask
`endif

  initial begin
    tests = 0; fails = 0; tcnt = 0;
    last_w = '0; f_act = '0; f_exp = '0;
    test_reset();
    test_stream();
    test_idle_insert();
    test_hold_no_idle();
`ifdef TX_GBOX_SCRAMBLER_EN
    test_scrambler();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
